route_walker: RTL and testbench

Downstream consumer of the small-path route generator in the 4-dimensional hypercube NoC. It accepts one packed route (up to 16 hops, 2-bit dimension index per hop) plus source node and hop count. It then issues the hops one at a time over a valid/ready interface, tracking the current node address by flipping the addressed dimension bit on each hop. It sits between the route generator and the per-router link arbiter.

---
 rtl/route_walker_if.sv | 33 +++
 rtl/route_walker.sv | 105 ++++++++++
 tb/tb_route_walker.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/route_walker_if.sv
// Route walker handshake bundle: route intake from the route generator and
// hop issue toward the link arbiter. master = the environment driving routes
// and consuming hops, slave = the walker itself.
interface route_walker_if #(
  parameter int DIM    = 4,
  parameter int MAXHOP = 16
);
  localparam int CW = $clog2(MAXHOP + 1);

  // Route intake
  logic                  path_valid;
  logic                  path_ready;
  logic [2*MAXHOP-1:0]   path_i;
  logic [CW-1:0]         hops_i;
  logic [DIM-1:0]        src_i;

  // Hop issue
  logic                  hop_valid;
  logic                  hop_ready;
  logic [1:0]            hop_dim_o;
  logic [DIM-1:0]        hop_node_o;
  logic                  hop_last_o;

  modport master (
    output path_valid, path_i, hops_i, src_i, hop_ready,
    input  path_ready, hop_valid, hop_dim_o, hop_node_o, hop_last_o
  );

  modport slave (
    input  path_valid, path_i, hops_i, src_i, hop_ready,
    output path_ready, hop_valid, hop_dim_o, hop_node_o, hop_last_o
  );
endinterface

// File: rtl/route_walker.sv
// Route walker: takes one packed hypercube route (2-bit dimension per hop,
// hop 0 in the LSBs) and issues its hops one at a time, tracking the current
// node by flipping the addressed dimension bit on every accepted hop.
module route_walker #(
  parameter int DIM    = 4,
  parameter int MAXHOP = 16
) (
  input  logic           clk,
  input  logic           rst,
  route_walker_if.slave  rw,
  output logic [DIM-1:0] cur_node_o,
  output logic           busy_o,
  output logic           done_o,
  output logic           err_o
);
  localparam int CW = $clog2(MAXHOP + 1);
  localparam logic [CW-1:0] MAX_HOPS = CW'(MAXHOP);
  localparam logic [CW-1:0] ONE_HOP  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [2*MAXHOP-1:0] sreg_q;
  logic [CW-1:0]       cnt_q;
  logic [DIM-1:0]      node_q;
  logic                err_q;

  logic [1:0]          hop_dim;
  logic [DIM-1:0]      hop_node;

  // The current hop's dimension is always the bottom pair of the shift register.
  assign hop_dim = sreg_q[1:0];

  // Next node: flip exactly the bit selected by the hop dimension (pure XOR).
  genvar gi;
  generate
    for (gi = 0; gi < DIM; gi++) begin : g_flip
      assign hop_node[gi] = node_q[gi] ^ (hop_dim == 2'(gi));
    end
  endgenerate

  // Handshake flags decode from state only; hop payload comes from registers.
  assign rw.path_ready = (state_q == IDLE);
  assign rw.hop_valid  = (state_q == WALK);
  assign rw.hop_dim_o  = hop_dim;
  assign rw.hop_node_o = hop_node;
  assign rw.hop_last_o = (state_q == WALK) && (cnt_q == ONE_HOP);

  assign cur_node_o = node_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);
  assign err_o      = err_q;

  // Route FSM: load in IDLE, shift out one hop per handshake in WALK,
  // single-cycle DONE before returning to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      node_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rw.path_valid) begin
            if (rw.hops_i > MAX_HOPS) begin
              // Oversized route: flag it and drop it without touching state.
              err_q <= 1'b1;
            end else if (rw.hops_i == '0) begin
              node_q  <= rw.src_i;
              state_q <= DONE;
            end else begin
              sreg_q  <= rw.path_i;
              cnt_q   <= rw.hops_i;
              node_q  <= rw.src_i;
              state_q <= WALK;
            end
          end
        end
        WALK: begin
          if (rw.hop_ready) begin
            node_q <= hop_node;
            sreg_q <= sreg_q >> 2;
            cnt_q  <= cnt_q - ONE_HOP;
            if (cnt_q == ONE_HOP) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_route_walker.sv
// Scoreboard bench for route_walker: stimulus pushes hand-computed hop,
// done and error expectations; a negedge monitor pops and compares them
// whenever the walker presents a hop, a done pulse or an error pulse.
module tb_route_walker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  route_walker_if #(.DIM(4), .MAXHOP(16)) rw ();

  logic [3:0] cur_node_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  route_walker #(.DIM(4), .MAXHOP(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .rw         (rw),
    .cur_node_o (cur_node_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  typedef struct packed {
    logic [1:0] dim;
    logic [3:0] node;
    logic       last;
  } hop_t;

  typedef struct packed {
    int unsigned cyc;
    logic [3:0]  node;
  } ev_t;

  hop_t hop_q[$];
  ev_t  done_q[$];
  ev_t  err_q[$];

  int          compared   = 0;
  int          mismatched = 0;
  int          hs_cnt     = 0;
  int unsigned cyc        = 0;
  logic        started    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Push hand-computed hops: dims packed 2 bits/hop, nodes packed 4 bits/hop.
  task automatic push_hops(input logic [31:0] dims, input logic [63:0] nodes,
                           input int n, input int total);
    hop_t h;
    for (int i = 0; i < n; i++) begin
      h.dim  = dims[2*i +: 2];
      h.node = nodes[4*i +: 4];
      h.last = (i == total - 1);
      hop_q.push_back(h);
    end
  endtask

  task automatic push_done(input int unsigned c, input logic [3:0] node);
    ev_t e;
    e.cyc  = c;
    e.node = node;
    done_q.push_back(e);
  endtask

  task automatic push_err(input int unsigned c, input logic [3:0] node);
    ev_t e;
    e.cyc  = c;
    e.node = node;
    err_q.push_back(e);
  endtask

  // Offer one route; returns the cycle index in which it was offered.
  // Returns #1 after the accepting edge (first cycle of the walk).
  task automatic offer(input logic [31:0] p, input logic [4:0] h, input logic [3:0] s,
                       output int unsigned k);
    int w = 0;
    while (rw.path_ready !== 1'b1 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk("path_ready_wait", 32'(rw.path_ready), 32'd1);
    rw.path_valid = 1'b1;
    rw.path_i     = p;
    rw.hops_i     = h;
    rw.src_i      = s;
    k = cyc;
    $display("route offered: path=0x%08h hops=%0d src=%0d cycle=%0d", p, h, s, k);
    @(posedge clk); #1;
    rw.path_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int w = 0;
    while ((rw.path_ready !== 1'b1 || hop_q.size() != 0 || done_q.size() != 0) && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk({name, "_completes"}, 32'(w < 100), 32'd1);
  endtask

  // Monitor: compare whatever the walker presents against the queue heads.
  always @(negedge clk) begin
    hop_t he;
    ev_t  ev;
    if (started && !rst) begin
      if (rw.hop_valid) begin
        chk("hop_expected", 32'(hop_q.size() != 0), 32'd1);
        if (hop_q.size() != 0) begin
          he = hop_q[0];
          chk(rw.hop_ready ? "hop" : "hop_hold",
              32'({rw.hop_dim_o, rw.hop_node_o, rw.hop_last_o}), 32'(he));
          if (rw.hop_ready) begin
            he = hop_q.pop_front();
            hs_cnt++;
            $display("hop: dim=%0d node=%0d last=%0d cur=%0d cycle=%0d",
                     rw.hop_dim_o, rw.hop_node_o, rw.hop_last_o, cur_node_o, cyc);
          end
        end
      end
      if (done_o) begin
        chk("done_expected", 32'(done_q.size() != 0), 32'd1);
        chk("done_err_excl", 32'(err_o), 32'd0);
        if (done_q.size() != 0) begin
          ev = done_q.pop_front();
          chk("done_cycle", cyc, ev.cyc);
          chk("done_node", 32'(cur_node_o), 32'(ev.node));
          $display("done: node=%0d cycle=%0d", cur_node_o, cyc);
        end
      end
      if (err_o) begin
        chk("err_expected", 32'(err_q.size() != 0), 32'd1);
        if (err_q.size() != 0) begin
          ev = err_q.pop_front();
          chk("err_cycle", cyc, ev.cyc);
          chk("err_node", 32'(cur_node_o), 32'(ev.node));
          $display("err: node=%0d cycle=%0d", cur_node_o, cyc);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    int          hs0;
    logic        pat [7];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    rw.path_valid = 1'b0;
    rw.path_i     = '0;
    rw.hops_i     = '0;
    rw.src_i      = '0;
    rw.hop_ready  = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    rst     = 1'b0;
    started = 1'b1;

    // Reset state
    chk("rst_path_ready", 32'(rw.path_ready), 32'd1);
    chk("rst_hop_valid",  32'(rw.hop_valid),  32'd0);
    chk("rst_hop_dim",    32'(rw.hop_dim_o),  32'd0);
    chk("rst_hop_last",   32'(rw.hop_last_o), 32'd0);
    chk("rst_cur_node",   32'(cur_node_o),    32'd0);
    chk("rst_busy",       32'(busy_o),        32'd0);
    chk("rst_done",       32'(done_o),        32'd0);
    chk("rst_err",        32'(err_o),         32'd0);

    // Basic 4-hop route from node 0: dims 0,1,0,2 -> nodes 1,3,2,6
    offer(32'h0000_0084, 5'd4, 4'd0, k);
    push_hops(32'h84, 64'h6231, 4, 4);
    push_done(k + 5, 4'd6);
    wait_idle("basic");
    chk("basic_final_node", 32'(cur_node_o), 32'd6);

    // Full 16-hop route from node 5
    offer(32'hC484_C484, 5'd16, 4'd5, k);
    push_hops(32'hC484_C484, 64'h5DCE_FBA8_9102_3764, 16, 16);
    push_done(k + 17, 4'd5);
    wait_idle("full");

    // Padding above the last hop must be ignored
    offer(32'hFFFF_FF84, 5'd4, 4'd0, k);
    push_hops(32'h84, 64'h6231, 4, 4);
    push_done(k + 5, 4'd6);
    wait_idle("padding");

    // Backpressure: hop_ready 1,0,0,1,0,1,1 from the first walk cycle
    hs0 = hs_cnt;
    offer(32'h0000_0084, 5'd4, 4'd0, k);
    push_hops(32'h84, 64'h6231, 4, 4);
    push_done(k + 8, 4'd6);
    for (int i = 0; i < 7; i++) begin
      rw.hop_ready = pat[i];
      @(posedge clk); #1;
    end
    rw.hop_ready = 1'b1;
    wait_idle("backpressure");
    chk("bp_handshakes", 32'(hs_cnt - hs0), 32'd4);
    chk("bp_final_node", 32'(cur_node_o), 32'd6);

    // Zero-hop route: straight to DONE with the source as current node
    offer(32'h0000_DEAD, 5'd0, 4'd9, k);
    push_done(k + 1, 4'd9);
    chk("zero_no_hop_valid", 32'(rw.hop_valid), 32'd0);
    wait_idle("zero");
    chk("zero_cur_node", 32'(cur_node_o), 32'd9);

    // Oversized route: err pulse, nothing loaded
    offer(32'h0000_0084, 5'd17, 4'd3, k);
    push_err(k + 1, 4'd9);
    chk("err_path_ready", 32'(rw.path_ready), 32'd1);
    chk("err_no_hop",     32'(rw.hop_valid),  32'd0);
    chk("err_busy",       32'(busy_o),        32'd0);
    chk("err_cur_node",   32'(cur_node_o),    32'd9);
    @(posedge clk); #1;
    chk("err_one_cycle",  32'(err_o),         32'd0);
    chk("err_node_kept",  32'(cur_node_o),    32'd9);

    // Reset after two hops aborts the route with no done pulse
    offer(32'h0000_0084, 5'd4, 4'd0, k);
    push_hops(32'h84, 64'h31, 2, 4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_hop_valid",  32'(rw.hop_valid),  32'd0);
    chk("abort_cur_node",   32'(cur_node_o),    32'd0);
    chk("abort_busy",       32'(busy_o),        32'd0);
    chk("abort_path_ready", 32'(rw.path_ready), 32'd1);
    repeat (20) @(posedge clk);
    #1;

    // Nothing may be left outstanding
    chk("left_hops", 32'(hop_q.size()),  32'd0);
    chk("left_done", 32'(done_q.size()), 32'd0);
    chk("left_err",  32'(err_q.size()),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
